// File: rtl/instr_decoder_pipe_if.sv
// Handshake bundle between instruction source, decoder and result consumer.
// Latency: none (wires only). Backpressure: in_ready / out_ready valid-ready pairs.
interface instr_decoder_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int MODE_BITS = 2
);
    localparam int NMODES = 2 ** MODE_BITS;
    localparam int OPW    = WIDTH - MODE_BITS;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [NMODES-1:0] out_mode;
    logic [OPW-1:0]    out_operand;
    logic [WIDTH-1:0]  out_ext_word;
    logic              out_is_ext;
    logic              ext_pending;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_mode, out_operand, out_ext_word, out_is_ext, ext_pending
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_mode, out_operand, out_ext_word, out_is_ext, ext_pending
    );
endinterface

// File: rtl/instr_decoder_pipe.sv
// Decodes instruction words into one-hot mode + operand; all-ones mode may take a second word.
// Latency: 1 cycle from accepting the last word of an instruction to out_valid.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); output held while stalled.
module instr_decoder_pipe #(
    parameter int WIDTH     = 8,
    parameter int MODE_BITS = 2,
    parameter bit EXT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    instr_decoder_pipe_if.slave   bus
);
    localparam int NMODES = 2 ** MODE_BITS;
    localparam int OPW    = WIDTH - MODE_BITS;

    typedef enum logic {IDLE = 1'b0, EXT_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  held_q, held_d;
    logic              out_valid_q, out_valid_d;
    logic [NMODES-1:0] out_mode_q, out_mode_d;
    logic [OPW-1:0]    out_operand_q, out_operand_d;
    logic [WIDTH-1:0]  out_ext_word_q, out_ext_word_d;
    logic              out_is_ext_q, out_is_ext_d;

    logic                 in_ready;
    logic                 in_acc;
    logic                 out_fire;
    logic [MODE_BITS-1:0] in_mode;
    logic [MODE_BITS-1:0] held_mode;
    logic                 is_ext_first;
    logic [NMODES-1:0]    in_onehot;
    logic [NMODES-1:0]    held_onehot;

    assign in_ready     = !flush && (!out_valid_q || bus.out_ready);
    assign in_acc       = bus.in_valid && in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;
    assign in_mode      = bus.in_instr[WIDTH-1 -: MODE_BITS];
    assign held_mode    = held_q[WIDTH-1 -: MODE_BITS];
    assign is_ext_first = EXT_EN && (&in_mode);

    always_comb begin
        in_onehot            = '0;
        in_onehot[in_mode]   = 1'b1;
        held_onehot          = '0;
        held_onehot[held_mode] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (in_acc && is_ext_first) state_d = EXT_WAIT;
                EXT_WAIT: if (in_acc)                 state_d = IDLE;
                default:                              state_d = IDLE;
            endcase
        end
    end

    // Output logic
    assign bus.ext_pending = (state_q == EXT_WAIT);

    // Result register and held first word
    always_comb begin
        held_d         = held_q;
        out_valid_d    = out_valid_q;
        out_mode_d     = out_mode_q;
        out_operand_d  = out_operand_q;
        out_ext_word_d = out_ext_word_q;
        out_is_ext_d   = out_is_ext_q;

        // A consumed result drops valid; out_mode must read zero while invalid.
        if (out_fire) begin
            out_valid_d = 1'b0;
            out_mode_d  = '0;
        end

        if (flush) begin
            held_d      = '0;
            out_valid_d = 1'b0;
            out_mode_d  = '0;
        end else if (in_acc) begin
            if (state_q == EXT_WAIT) begin
                out_valid_d    = 1'b1;
                out_mode_d     = held_onehot;
                out_operand_d  = held_q[OPW-1:0];
                out_ext_word_d = bus.in_instr;
                out_is_ext_d   = 1'b1;
                held_d         = '0;
            end else if (is_ext_first) begin
                held_d = bus.in_instr;
            end else begin
                out_valid_d    = 1'b1;
                out_mode_d     = in_onehot;
                out_operand_d  = bus.in_instr[OPW-1:0];
                out_ext_word_d = '0;
                out_is_ext_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q         <= '0;
            out_valid_q    <= 1'b0;
            out_mode_q     <= '0;
            out_operand_q  <= '0;
            out_ext_word_q <= '0;
            out_is_ext_q   <= 1'b0;
        end else begin
            held_q         <= held_d;
            out_valid_q    <= out_valid_d;
            out_mode_q     <= out_mode_d;
            out_operand_q  <= out_operand_d;
            out_ext_word_q <= out_ext_word_d;
            out_is_ext_q   <= out_is_ext_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_mode     = out_mode_q;
    assign bus.out_operand  = out_operand_q;
    assign bus.out_ext_word = out_ext_word_q;
    assign bus.out_is_ext   = out_is_ext_q;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe at WIDTH=8, MODE_BITS=2, EXT_EN=1.
module tb_instr_decoder_pipe;
    logic clk;
    logic rst_n;
    logic flush;

    int n_chk;
    int n_err;

    instr_decoder_pipe_if #(.WIDTH(8), .MODE_BITS(2)) bus ();

    instr_decoder_pipe #(.WIDTH(8), .MODE_BITS(2), .EXT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] w);
        bus.in_valid = v;
        bus.in_instr = w;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 8'h00;
        bus.out_ready = 1'b1;

        #3;
        chk("rst_valid",   bus.out_valid,    0);
        chk("rst_mode",    bus.out_mode,     0);
        chk("rst_operand", bus.out_operand,  0);
        chk("rst_ext",     bus.out_ext_word, 0);
        chk("rst_is_ext",  bus.out_is_ext,   0);
        chk("rst_pending", bus.ext_pending,  0);

        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", bus.in_ready, 1);

        // Single-word decode
        drive(1'b1, 8'h25);
        step();
        chk("s25_valid",   bus.out_valid,   1);
        chk("s25_mode",    bus.out_mode,    4'b0001);
        chk("s25_operand", bus.out_operand, 6'h25);
        chk("s25_is_ext",  bus.out_is_ext,  0);
        chk("s25_extw",    bus.out_ext_word, 0);

        // Back-to-back at full throughput
        drive(1'b1, 8'h41);
        chk("b2b_ready0", bus.in_ready, 1);
        step();
        chk("b41_mode",    bus.out_mode,    4'b0010);
        chk("b41_operand", bus.out_operand, 6'h01);
        drive(1'b1, 8'h82);
        chk("b2b_ready1", bus.in_ready, 1);
        step();
        chk("b82_mode",    bus.out_mode,    4'b0100);
        chk("b82_operand", bus.out_operand, 6'h02);
        chk("b82_valid",   bus.out_valid,   1);

        drive(1'b0, 8'h00);
        step();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_mode",  bus.out_mode,  0);

        // Extended instruction
        drive(1'b1, 8'hC3);
        step();
        chk("xC3_pending", bus.ext_pending, 1);
        chk("xC3_valid",   bus.out_valid,   0);
        drive(1'b1, 8'h5A);
        step();
        chk("x5A_pending", bus.ext_pending,  0);
        chk("x5A_valid",   bus.out_valid,    1);
        chk("x5A_mode",    bus.out_mode,     4'b1000);
        chk("x5A_operand", bus.out_operand,  6'h03);
        chk("x5A_extw",    bus.out_ext_word, 8'h5A);
        chk("x5A_is_ext",  bus.out_is_ext,   1);
        drive(1'b0, 8'h00);
        step();

        // Stall: output frozen, nothing consumed
        drive(1'b1, 8'h10);
        step();
        chk("st10_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h20);
        chk("stall_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid",   bus.out_valid,   1);
            chk("stall_mode",    bus.out_mode,    4'b0001);
            chk("stall_operand", bus.out_operand, 6'h10);
            chk("stall_ready_k", bus.in_ready,    0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_ready", bus.in_ready, 1);
        step();
        chk("st20_valid",   bus.out_valid,   1);
        chk("st20_operand", bus.out_operand, 6'h20);
        chk("st20_mode",    bus.out_mode,    4'b0001);
        drive(1'b0, 8'h00);
        step();

        // Reset in the middle of an extended instruction
        drive(1'b1, 8'hC7);
        step();
        chk("rC7_pending", bus.ext_pending, 1);
        drive(1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("mrst_pending", bus.ext_pending, 0);
        chk("mrst_valid",   bus.out_valid,   0);
        chk("mrst_operand", bus.out_operand, 0);
        chk("mrst_mode",    bus.out_mode,    0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 8'h7F);
        step();
        chk("r7F_mode",    bus.out_mode,    4'b0010);
        chk("r7F_operand", bus.out_operand, 6'h3F);
        chk("r7F_is_ext",  bus.out_is_ext,  0);
        chk("r7F_pending", bus.ext_pending, 0);
        drive(1'b0, 8'h00);
        step();

        // Flush in the middle of an extended instruction
        drive(1'b1, 8'hC7);
        step();
        chk("fC7_pending", bus.ext_pending, 1);
        flush = 1'b1;
        drive(1'b1, 8'h11);
        chk("flush_ready", bus.in_ready, 0);
        step();
        flush = 1'b0;
        drive(1'b1, 8'hC1);
        chk("fl_pending", bus.ext_pending, 0);
        chk("fl_valid",   bus.out_valid,   0);
        step();
        chk("fC1_pending", bus.ext_pending, 1);
        drive(1'b1, 8'hFF);
        step();
        chk("fFF_valid",   bus.out_valid,    1);
        chk("fFF_mode",    bus.out_mode,     4'b1000);
        chk("fFF_operand", bus.out_operand,  6'h01);
        chk("fFF_extw",    bus.out_ext_word, 8'hFF);
        chk("fFF_is_ext",  bus.out_is_ext,   1);
        drive(1'b0, 8'h00);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
